// File: rtl/bram_stream_packer.sv
// Packs consecutive BRAM read words into wide AXI-Stream beats.
// A small beat FIFO absorbs downstream back-pressure.
module bram_stream_packer #(
    parameter int DATA_W     = 16,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       bram_rd_enable,
    input  logic                       rd_last,
    input  logic [DATA_W-1:0]          bram_rd_data,
    output logic [DATA_W*LANES-1:0]    m_axis_tdata,
    output logic [DATA_W*LANES/8-1:0]  m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       pack_ready,
    output logic                       overflow,
    output logic [15:0]                beats_sent
);

    localparam int BEAT_W    = DATA_W * LANES;
    localparam int KEEP_W    = BEAT_W / 8;
    localparam int LANE_KEEP = DATA_W / 8;
    localparam int IDX_W     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int ENTRY_W   = BEAT_W + KEEP_W + 1;

    logic                          cap_valid_q;
    logic                          cap_last_q;
    logic [IDX_W-1:0]              idx_q;
    logic [IDX_W-1:0]              idx_d;
    logic [LANES-1:0][DATA_W-1:0]  lane_q;

    logic [BEAT_W-1:0]             beat_data_s;
    logic [KEEP_W-1:0]             beat_keep_s;
    logic                          beat_done_s;

    logic [ENTRY_W-1:0]            mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr_q;
    logic [PTR_W-1:0]              rd_ptr_q;
    logic [CNT_W-1:0]              count_q;
    logic [CNT_W-1:0]              count_d;
    logic                          empty_s;
    logic                          full_s;
    logic                          push_s;
    logic                          pop_s;
    logic                          overflow_q;
    logic [15:0]                   beats_sent_q;
    logic [ENTRY_W-1:0]            head_s;

    // Assemble the outgoing beat: earlier lanes from the accumulator, the
    // current lane straight from the BRAM bus, later lanes zero-filled.
    always_comb begin
        beat_data_s = '0;
        beat_keep_s = '0;
        for (int j = 0; j < LANES; j++) begin
            if (j < int'(idx_q)) begin
                beat_data_s[j*DATA_W +: DATA_W]       = lane_q[j];
                beat_keep_s[j*LANE_KEEP +: LANE_KEEP] = '1;
            end else if (j == int'(idx_q)) begin
                beat_data_s[j*DATA_W +: DATA_W]       = bram_rd_data;
                beat_keep_s[j*LANE_KEEP +: LANE_KEEP] = '1;
            end else begin
                beat_data_s[j*DATA_W +: DATA_W]       = '0;
                beat_keep_s[j*LANE_KEEP +: LANE_KEEP] = '0;
            end
        end
    end

    // Beat completion and next lane index.
    always_comb begin
        beat_done_s = cap_valid_q && ((idx_q == IDX_W'(LANES - 1)) || cap_last_q);
        if (!cap_valid_q) begin
            idx_d = idx_q;
        end else if (beat_done_s) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    // FIFO handshake decode; a push on a full FIFO is only legal alongside a pop.
    always_comb begin
        empty_s = (count_q == '0);
        full_s  = (count_q == CNT_W'(FIFO_DEPTH));
        pop_s   = !empty_s && m_axis_tready;
        push_s  = beat_done_s && (!full_s || pop_s);
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: capture stage, accumulator, FIFO pointers and status.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cap_valid_q  <= 1'b0;
            cap_last_q   <= 1'b0;
            idx_q        <= '0;
            lane_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            beats_sent_q <= 16'h0000;
        end else begin
            cap_valid_q <= bram_rd_enable;
            cap_last_q  <= bram_rd_enable && rd_last;
            if (cap_valid_q) begin
                lane_q[idx_q] <= bram_rd_data;
            end
            idx_q <= idx_d;
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
                beats_sent_q <= beats_sent_q + 16'd1;
            end
            count_q <= count_d;
            if (beat_done_s && full_s && !pop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Beat storage; contents are only observable while the FIFO is non-empty.
    always_ff @(posedge aclk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {cap_last_q, beat_keep_s, beat_data_s};
        end
    end

    assign head_s        = mem_q[rd_ptr_q];
    assign m_axis_tvalid = !empty_s;
    assign m_axis_tdata  = empty_s ? '0 : head_s[BEAT_W-1:0];
    assign m_axis_tkeep  = empty_s ? '0 : head_s[BEAT_W +: KEEP_W];
    assign m_axis_tlast  = !empty_s && head_s[ENTRY_W-1];
    // Two free slots cover the beat in the capture stage plus the partial one.
    assign pack_ready    = (count_q <= CNT_W'(FIFO_DEPTH - 2));
    assign overflow      = overflow_q;
    assign beats_sent    = beats_sent_q;

endmodule
